// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one 4-phase bundled-data channel among N_REQ 4-phase requesters.
// Optional macro HS_ARB_SYNC_EN adds 2-flop synchronizers on req_i and out_ack_i.
module hs_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic                      out_req_o,
  output logic [DATA_W-1:0]         out_data_o,
  input  logic                      out_ack_i,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_ACK,
    WAIT_CREQ_LO,
    WAIT_OACK_LO
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               out_req_q, out_req_d;
  logic               busy_q, busy_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [N_REQ-1:0]   req_s;
  logic               oack_s;

`ifdef HS_ARB_SYNC_EN
  logic [N_REQ-1:0]   req_m_q, req_s_q;
  logic               oack_m_q, oack_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_m_q  <= '0;
      req_s_q  <= '0;
      oack_m_q <= 1'b0;
      oack_s_q <= 1'b0;
    end else begin
      req_m_q  <= req_i;
      req_s_q  <= req_m_q;
      oack_m_q <= out_ack_i;
      oack_s_q <= oack_m_q;
    end
  end

  assign req_s  = req_s_q;
  assign oack_s = oack_s_q;
`else
  assign req_s  = req_i;
  assign oack_s = out_ack_i;
`endif

  // Rotating priority search starting at ptr_q.
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  int               rot_j;

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    rot_j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rot_j = (int'(ptr_q) + k) % N_REQ;
      if (!win_vld && req_s[rot_j]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(rot_j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    ack_d     = ack_q;
    out_req_d = out_req_q;
    busy_d    = busy_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          idx_d   = win_idx;
          data_d  = req_data_i[win_idx*DATA_W +: DATA_W];
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        out_req_d = 1'b1;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (oack_s) begin
          ack_d        = '0;
          ack_d[idx_q] = 1'b1;
          state_d      = WAIT_CREQ_LO;
        end
      end
      WAIT_CREQ_LO: begin
        if (!req_s[idx_q]) begin
          out_req_d = 1'b0;
          state_d   = WAIT_OACK_LO;
        end
      end
      WAIT_OACK_LO: begin
        if (!oack_s) begin
          ack_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any handshake in flight on both sides at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      ack_q     <= '0;
      out_req_q <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      ack_q     <= ack_d;
      out_req_q <= out_req_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
    end
  end

  assign ack_o       = ack_q;
  assign out_req_o   = out_req_q;
  assign out_data_o  = data_q;
  assign grant_idx_o = idx_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Bench for hs_rr_arbiter: directed handshake timing plus randomized clients/responder
// checked against a transaction-level round-robin model.
module tb_hs_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef HS_ARB_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    ack_o;
  logic            out_req_o;
  logic [DW-1:0]   out_data_o;
  logic            out_ack_i;
  logic [IW-1:0]   grant_idx_o;
  logic            busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hs_rr_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .req_data_i (req_data_i),
    .ack_o      (ack_o),
    .out_req_o  (out_req_o),
    .out_data_o (out_data_o),
    .out_ack_i  (out_ack_i),
    .grant_idx_o(grant_idx_o),
    .busy_o     (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: rotating priority from the model pointer, 4-phase causality.
  int              glog[$];
  logic [N-1:0]    h_req [3];
  logic            h_oack[3];
  int              model_ptr = 0;
  int              cur = 0;
  int              cyc = 0;
  int              exp_w;
  logic            m_rst = 1'b1;
  logic            m_busy = 1'b0;
  logic            m_oreq = 1'b0;
  logic [N-1:0]    m_ack = '0;
  logic [N*DW-1:0] m_data = '0;
  logic [DW-1:0]   g_data = '0;
  logic [N-1:0]    rq;
  logic            oa;

  always @(negedge clk) begin
    if (m_rst) begin
      model_ptr = 0;
      cyc = 0;
      for (int k = 0; k < 3; k++) begin
        h_req[k]  = '0;
        h_oack[k] = 1'b0;
      end
    end else begin
      rq = h_req[L];
      oa = h_oack[L];
      if (busy_o && !m_busy) begin
        exp_w = -1;
        for (int k = 0; k < N; k++)
          if (exp_w < 0 && rq[(model_ptr + k) % N]) exp_w = (model_ptr + k) % N;
        check("grant_has_req", 32'(rq != '0), 32'd1);
        check("grant_idx", 32'(grant_idx_o), 32'(exp_w));
        cur = (exp_w < 0) ? int'(grant_idx_o) : exp_w;
        g_data = m_data[cur*DW +: DW];
        check("grant_data", out_data_o, g_data);
        check("grant_quiet", 32'({out_req_o, ack_o}), 32'd0);
        glog.push_back(int'(grant_idx_o));
        cyc = 0;
      end else if (busy_o) begin
        cyc++;
      end
      if (out_req_o && !m_oreq) begin
        check("oreq_latency", 32'(cyc), 32'd1);
        check("oreq_data_hold", out_data_o, g_data);
      end
      if (ack_o != m_ack) begin
        if (ack_o != '0) begin
          check("ack_onehot", 32'(ack_o), 32'd1 << cur);
          check("ack_cause", 32'(oa), 32'd1);
        end else begin
          check("ack_release", 32'({busy_o, oa}), 32'd0);
        end
      end
      if (!out_req_o && m_oreq) check("oreq_drop_cause", 32'(rq[cur]), 32'd0);
      if (!busy_o && m_busy) model_ptr = (cur + 1) % N;
    end
    m_rst  = rst;
    m_busy = busy_o;
    m_oreq = out_req_o;
    m_ack  = ack_o;
    m_data = req_data_i;
    h_req[2]  = h_req[1];  h_req[1]  = h_req[0];  h_req[0]  = req_i;
    h_oack[2] = h_oack[1]; h_oack[1] = h_oack[0]; h_oack[0] = out_ack_i;
  end

  // Behavioural 4-phase clients and downstream responder.
  logic auto_en;
  bit   eager;
  int   want_cnt[N];
  int   resp_dly;
  int   dly_cnt;

  task automatic auto_drive();
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && ack_o[i]) begin
        req_i[i] = 1'b0;
      end else if (!req_i[i] && !ack_o[i] && want_cnt[i] > 0 &&
                   (eager || $urandom_range(0, 3) == 0)) begin
        req_data_i[i*DW +: DW] = $urandom;
        req_i[i] = 1'b1;
        want_cnt[i]--;
      end
    end
    if (out_ack_i != out_req_o) begin
      if (dly_cnt >= resp_dly) begin
        out_ack_i = out_req_o;
        dly_cnt = 0;
      end else begin
        dly_cnt++;
      end
    end else begin
      dly_cnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_en) auto_drive();
  endtask

  function automatic bit tb_active();
    bit a;
    a = (req_i != '0) || busy_o || out_ack_i;
    for (int i = 0; i < N; i++) if (want_cnt[i] > 0) a = 1'b1;
    return a;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (tb_active() && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"},   32'(ack_o), 32'd0);
    check({tag, "_oreq"},  32'(out_req_o), 32'd0);
    check({tag, "_data"},  out_data_o, 32'd0);
    check({tag, "_grant"}, 32'(grant_idx_o), 32'd0);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};
  int total;
  int n;

  initial begin
    rst = 1'b1; req_i = '0; req_data_i = '0; out_ack_i = 1'b0;
    auto_en = 1'b0; eager = 1'b0; resp_dly = 0; dly_cnt = 0;
    for (int i = 0; i < N; i++) want_cnt[i] = 0;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Single client with exact handshake timing.
    req_data_i[1*DW +: DW] = 32'hDEADBEEF;
    req_i = 4'b0010;
    repeat (1 + L) tick();
    check("s1_busy", 32'(busy_o), 32'd1);
    check("s1_grant", 32'(grant_idx_o), 32'd1);
    check("s1_data", out_data_o, 32'hDEADBEEF);
    check("s1_oreq_lo", 32'(out_req_o), 32'd0);
    tick();
    check("s1_oreq", 32'(out_req_o), 32'd1);
    out_ack_i = 1'b1;
    repeat (1 + L) tick();
    check("s1_ack", 32'(ack_o), 32'b0010);
    req_i = '0;
    repeat (1 + L) tick();
    check("s1_oreq_drop", 32'(out_req_o), 32'd0);
    check("s1_ack_hold", 32'(ack_o), 32'b0010);
    out_ack_i = 1'b0;
    repeat (1 + L) tick();
    check("s1_idle", 32'(busy_o), 32'd0);
    check("s1_ack_clr", 32'(ack_o), 32'd0);
    check("s1_data_hold", out_data_o, 32'hDEADBEEF);

    // Pointer now at 2: clients 0 and 2 together, 2 goes first.
    glog.delete();
    auto_en = 1'b1; eager = 1'b1;
    want_cnt[0] = 1; want_cnt[2] = 1;
    drain("ptr2", 200);
    check("ptr2_n", 32'(glog.size()), 32'd2);
    check("ptr2_first", 32'(glog[0]), 32'd2);
    check("ptr2_second", 32'(glog[1]), 32'd0);

    // All four continuously requesting from reset.
    glog.delete();
    pulse_reset();
    for (int i = 0; i < N; i++) want_cnt[i] = 2;
    drain("rr", 400);
    check("rr_n", 32'(glog.size()), 32'd8);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(glog[k]), 32'(rr_exp[k]));

    // Wrap: client 2 alone leaves ptr at 3, then 1 and 3 compete.
    pulse_reset();
    glog.delete();
    want_cnt[2] = 1;
    drain("wrap_a", 200);
    want_cnt[1] = 1; want_cnt[3] = 1;
    drain("wrap_b", 200);
    check("wrap_n", 32'(glog.size()), 32'd3);
    check("wrap_first", 32'(glog[1]), 32'd3);
    check("wrap_second", 32'(glog[2]), 32'd1);

    // Late requester: client 2 raises while client 0 waits for downstream ack.
    glog.delete();
    resp_dly = 4;
    want_cnt[0] = 1;
    for (n = 0; n < 30 && !out_req_o; n++) tick();
    check("late_oreq_seen", 32'(out_req_o), 32'd1);
    want_cnt[2] = 1;
    drain("late", 200);
    check("late_n", 32'(glog.size()), 32'd2);
    check("late_first", 32'(glog[0]), 32'd0);
    check("late_second", 32'(glog[1]), 32'd2);

    // Reset while the arbiter waits for the client to drop its request.
    auto_en = 1'b0; resp_dly = 0;
    req_data_i[0 +: DW] = 32'h1234_5678;
    req_i = 4'b0001;
    for (n = 0; n < 30 && !out_req_o; n++) tick();
    check("mid_oreq_seen", 32'(out_req_o), 32'd1);
    out_ack_i = 1'b1;
    for (n = 0; n < 30 && !ack_o[0]; n++) tick();
    check("mid_ack_seen", 32'(ack_o), 32'b0001);
    rst = 1'b1; req_i = '0; out_ack_i = 1'b0;
    tick();
    check_zero_outputs("midrst");
    rst = 1'b0;
    glog.delete();
    auto_en = 1'b1;
    want_cnt[0] = 1; want_cnt[3] = 1;
    drain("midrst_after", 200);
    check("midrst_n", 32'(glog.size()), 32'd2);
    check("midrst_first", 32'(glog[0]), 32'd0);
    check("midrst_second", 32'(glog[1]), 32'd3);

    // Randomized traffic and responder latency.
    glog.delete();
    eager = 1'b0;
    total = 0;
    for (int i = 0; i < N; i++) begin
      want_cnt[i] = $urandom_range(5, 12);
      total += want_cnt[i];
    end
    for (int r = 0; r < 40; r++) begin
      resp_dly = $urandom_range(0, 3);
      repeat (25) tick();
    end
    drain("rand", 3000);
    check("rand_n", 32'(glog.size()), 32'(total));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
